// File: rtl/ex_stage_if.sv
// Bundle of ID/EX inputs, the MEM/WB forward source and the EX/MEM outputs of the execute stage.
// Latency: none, wiring only.
// Backpressure: busy travels from the stage (slave) back to the front end (master).
interface ex_stage_if #(
    parameter int W  = 8,
    parameter int RW = 5
);
    logic          id_valid;
    logic [2:0]    alu_sig;
    logic          wb_in;
    logic [W-1:0]  r1;
    logic [W-1:0]  r2;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic          flush;
    logic          mw_we;
    logic [RW-1:0] mw_rd;
    logic [W-1:0]  mw_data;
    logic          busy;
    logic          exm_valid;
    logic          exm_wb;
    logic [RW-1:0] exm_rd;
    logic [W-1:0]  exm_result;

    modport master (
        output id_valid, alu_sig, wb_in, r1, r2, rs, rt, rd, flush, mw_we, mw_rd, mw_data,
        input  busy, exm_valid, exm_wb, exm_rd, exm_result
    );

    modport slave (
        input  id_valid, alu_sig, wb_in, r1, r2, rs, rt, rd, flush, mw_we, mw_rd, mw_data,
        output busy, exm_valid, exm_wb, exm_rd, exm_result
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding (EX_FWD_EN), 8-op ALU, iterative shift-add multiplier, EX/MEM register.
// Latency: 1 cycle for ALU ops, W+1 edges for MUL.
// Backpressure: busy (combinational) holds IF/ID and ID/EX while a multiply is in flight.
module ex_stage #(
    parameter int W  = 8,
    parameter int RW = 5
) (
    input logic       clk,
    input logic       rst_n,
    ex_stage_if.slave exb
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_NOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]  mplier_q, mplier_d;
    logic [RW-1:0] mrd_q, mrd_d;
    logic          mwb_q, mwb_d;
    logic          exm_valid_q, exm_valid_d;
    logic          exm_wb_q, exm_wb_d;
    logic [RW-1:0] exm_rd_q, exm_rd_d;
    logic [W-1:0]  exm_result_q, exm_result_d;

    logic [W-1:0]  op_a, op_b, alu_res, acc_sum;
    logic          busy;
    logic          mul_last;

`ifdef EX_FWD_EN
    // Operand select: the younger EX/MEM result beats MEM/WB; r0 is never forwarded.
    always_comb begin
        op_a = exb.r1;
        op_b = exb.r2;
        if (exm_valid_q && exm_wb_q && exm_rd_q == exb.rs && exb.rs != '0)
            op_a = exm_result_q;
        else if (exb.mw_we && exb.mw_rd == exb.rs && exb.rs != '0)
            op_a = exb.mw_data;
        if (exm_valid_q && exm_wb_q && exm_rd_q == exb.rt && exb.rt != '0)
            op_b = exm_result_q;
        else if (exb.mw_we && exb.mw_rd == exb.rt && exb.rt != '0)
            op_b = exb.mw_data;
    end
`else
    logic unused_mw;
    assign unused_mw = ^{exb.mw_we, exb.mw_rd, exb.mw_data};

    // Without forwarding the register-file operands are used as-is.
    always_comb begin
        op_a = exb.r1;
        op_b = exb.r2;
    end
`endif

    // Single-cycle ALU; MUL produces nothing here, the multiplier owns that result.
    always_comb begin
        alu_res = '0;
        case (exb.alu_sig)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_SLT:  alu_res = {{(W-1){1'b0}}, (op_a < op_b)};
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_MUL:  alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    assign acc_sum  = acc_q + (mcand_q[0] ? mplier_q : '0);
    assign mul_last = (cnt_q == CW'(W - 1));

    // Next-state: EX/MEM load, multiplier start/step/finish, flush abort and busy.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        mrd_d        = mrd_q;
        mwb_d        = mwb_q;
        exm_valid_d  = 1'b0;
        exm_wb_d     = 1'b0;
        exm_rd_d     = exm_rd_q;
        exm_result_d = exm_result_q;
        busy         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                exm_rd_d     = exb.rd;
                exm_result_d = alu_res;
                if (exb.flush) begin
                    // Killed instruction: EX/MEM takes a bubble, a MUL never starts.
                end else if (exb.id_valid && exb.alu_sig == OP_MUL) begin
                    busy     = 1'b1;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    mrd_d    = exb.rd;
                    mwb_d    = exb.wb_in;
                    state_d  = ST_MUL;
                end else begin
                    exm_valid_d = exb.id_valid;
                    exm_wb_d    = exb.wb_in & exb.id_valid;
                end
            end
            ST_MUL: begin
                if (exb.flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q >> 1;
                    mplier_d = mplier_q << 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (mul_last) begin
                        // Final step lands straight in EX/MEM; ID/EX advances on this edge.
                        exm_valid_d  = 1'b1;
                        exm_wb_d     = mwb_q;
                        exm_rd_d     = mrd_q;
                        exm_result_d = acc_sum;
                        state_d      = ST_IDLE;
                        cnt_d        = '0;
                    end else begin
                        busy = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and EX/MEM registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            mrd_q        <= '0;
            mwb_q        <= 1'b0;
            exm_valid_q  <= 1'b0;
            exm_wb_q     <= 1'b0;
            exm_rd_q     <= '0;
            exm_result_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            mrd_q        <= mrd_d;
            mwb_q        <= mwb_d;
            exm_valid_q  <= exm_valid_d;
            exm_wb_q     <= exm_wb_d;
            exm_rd_q     <= exm_rd_d;
            exm_result_q <= exm_result_d;
        end
    end

    assign exb.busy       = busy;
    assign exb.exm_valid  = exm_valid_q;
    assign exb.exm_wb     = exm_wb_q;
    assign exb.exm_rd     = exm_rd_q;
    assign exb.exm_result = exm_result_q;
endmodule
